mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous unified memory between the pipeline fetch port (IF) and data port (MEM).

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 15 +
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, access-size codes and byte-lane helpers for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, IF_RD, DM_RD, RMW_RD, RMW_WR} arb_state_e;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] ln, input logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    return sz == SIZE_BYTE ? {{24{b[7] & ~uns}}, b} :
           sz == SIZE_HALF ? {{16{h[15] & ~uns}}, h} : w;
  endfunction
  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = w;
    if (sz == SIZE_BYTE) r[{ln, 3'b000} +: 8] = d[7:0];
    else if (sz == SIZE_HALF) r[{ln[1], 4'b0000} +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational load extraction and sub-word store merge for one 32-bit word
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);
  assign o_ext    = lane_extract(i_rdata, i_size, i_lane, i_unsigned);
  assign o_merged = lane_merge(i_rdata, i_wdata, i_size, i_lane);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory between fetch and data ports; MEM_ARB_MISALIGN_EN adds misaligned-access rejection
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic              dm_unsigned,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_MISALIGN_EN
  ,
  output logic              misalign
`endif
);
  arb_state_e r_state;
  logic r_last_dm;
  logic [DATA_W-1:0] r_wbuf;
  logic [DATA_W-1:0] w_ext, w_merged;
  logic w_word, w_mis, w_idle, w_dm_grant, w_if_grant, w_dm_io, w_done_now, w_wr_now, w_dm_rd;
  logic w_unused;
  assign w_unused = &{1'b0, if_addr[1:0]};
  assign w_word = dm_size != SIZE_HALF && dm_size != SIZE_BYTE;
`ifdef MEM_ARB_MISALIGN_EN
  assign w_mis    = dm_size == SIZE_HALF ? dm_addr[0] : w_word && dm_addr[1:0] != 2'b00;
  assign misalign = w_dm_grant && w_mis;
`else
  assign w_mis = 1'b0;
`endif
  assign w_idle     = reset && r_state == IDLE;
  assign w_dm_grant = w_idle && dm_req && !(r_last_dm && if_req);
  assign w_if_grant = w_idle && if_req && !w_dm_grant;
  assign w_dm_io    = w_dm_grant && !w_mis;
  assign w_done_now = w_mis || (dm_we && w_word);
  assign w_wr_now   = reset && r_state == RMW_WR;
  assign w_dm_rd    = reset && r_state == DM_RD;
  assign mem_en     = w_if_grant || w_dm_io || w_wr_now;
  assign mem_we     = (w_dm_io && dm_we && w_word) || w_wr_now;
  assign mem_addr   = mem_en ? {(w_if_grant ? if_addr[ADDR_W-1:2] : dm_addr[ADDR_W-1:2]), 2'b00} : '0;
  assign mem_wdata  = mem_we ? (w_wr_now ? r_wbuf : dm_wdata) : '0;
  assign if_ready   = reset && r_state == IF_RD;
  assign if_rdata   = if_ready ? mem_rdata : '0;
  assign dm_ready   = w_dm_rd || w_wr_now || (w_dm_grant && w_done_now);
  assign dm_rdata   = w_dm_rd ? w_ext : '0;
  mem_lane_align u_align (
    .i_rdata   (mem_rdata),
    .i_wdata   (dm_wdata),
    .i_size    (dm_size),
    .i_lane    (dm_addr[1:0]),
    .i_unsigned(dm_unsigned),
    .o_ext     (w_ext),
    .o_merged  (w_merged)
  );
  // arbitration FSM with fetch-fairness flag and read-modify-write buffer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last_dm <= 1'b0;
      r_wbuf    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dm_grant) begin
            r_state   <= w_done_now ? IDLE : dm_we ? RMW_RD : DM_RD;
            r_last_dm <= w_done_now ? 1'b1 : r_last_dm;
          end else if (w_if_grant) r_state <= IF_RD;
        end
        IF_RD: begin
          r_last_dm <= 1'b0;
          r_state   <= IDLE;
        end
        DM_RD, RMW_WR: begin
          r_last_dm <= 1'b1;
          r_state   <= IDLE;
        end
        RMW_RD: begin
          r_wbuf  <= w_merged;
          r_state <= RMW_WR;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter against a behavioural memory/port model
module tb_mem_port_arbiter;
`ifdef MEM_ARB_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
  logic misalign;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_unsigned = 1'b0;
  logic [1:0] dm_size = 2'b00;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata = '0;
  logic if_ready, dm_ready, mem_en, mem_we;
  logic [31:0] mem [0:63];
  logic [31:0] exp_mem [0:63];
  logic pl_en = 1'b0;
  logic [5:0] pl_idx = '0;
  logic [31:0] pl_data = '0;
  int n_cmp = 0, n_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_MISALIGN_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:2]];
  end

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] a, input logic uns);
    logic [31:0] v;
    if (sz == 2'd2) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] m;
    logic [31:0] sh;
    if (sz == 2'd2) begin
      sh = 8 * (a % 4);
      m = 32'hFF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * ((a / 2) % 2);
      m = 32'hFFFF << sh;
    end else begin
      sh = 0;
      m = '1;
    end
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    return MIS_EN && ((sz == 2'd1 && a[0]) || ((sz == 2'd0 || sz == 2'd3) && a[1:0] != 2'b00));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_idx = a[7:2];
    pl_data = d;
    exp_mem[a[7:2]] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd, output int nw);
    dm_req = 1'b1; dm_we = we; dm_size = sz; dm_unsigned = uns; dm_addr = a; dm_wdata = wd;
    lat = 0; nw = 0; rd = 'x;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_en && mem_we) nw++;
      if (dm_ready) begin
        lat = c;
        rd = dm_rdata;
      end
      tick();
    end
    dm_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if_req = 1'($urandom_range(0, 1)); dm_req = 1'($urandom_range(0, 1));
      dm_we = 1'($urandom_range(0, 1)); dm_size = 2'($urandom_range(0, 3));
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      pl_en = 1'b1; pl_idx = 6'(i); pl_data = $urandom; exp_mem[i] = pl_data;
      @(negedge clk);
      n_cmp++;
      if ({if_ready, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got rdy=%b%b en=%b we=%b addr=%h wd=%h ird=%h drd=%h want all 0",
                 i, if_ready, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      tick();
    end
    pl_en = 1'b0; if_req = 1'b0; dm_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if_ready, dm_ready, mem_en, mem_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_after_reset: got rdy=%b%b en=%b we=%b want 0000", if_ready, dm_ready, mem_en, mem_we);
    end
    tick();
  endtask

  task automatic test_directed;
    int lat, nw;
    logic [31:0] rd;
    set_word(32'h10, 32'hDEADBEEF);
    do_dm(1'b0, 2'b00, 1'b0, 32'h10, '0, lat, rd, nw);
    n_cmp++;
    if (lat !== 2 || rd !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL word_load: got lat=%0d data=%h want lat=2 data=deadbeef", lat, rd);
    end
    set_word(32'h10, 32'h80FF0011);
    do_dm(1'b0, 2'b10, 1'b0, 32'h13, '0, lat, rd, nw);
    n_cmp++;
    if (rd !== 32'hFFFFFF80) begin
      n_err++;
      $display("FAIL byte_load_signed: got %h want ffffff80", rd);
    end
    do_dm(1'b0, 2'b10, 1'b1, 32'h13, '0, lat, rd, nw);
    n_cmp++;
    if (rd !== 32'h00000080) begin
      n_err++;
      $display("FAIL byte_load_unsigned: got %h want 00000080", rd);
    end
    set_word(32'h20, 32'h11223344);
    do_dm(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, lat, rd, nw);
    n_cmp++;
    if (lat !== 3 || nw !== 1 || mem[8] !== 32'hABCD3344) begin
      n_err++;
      $display("FAIL half_store: got lat=%0d writes=%0d mem=%h want lat=3 writes=1 mem=abcd3344", lat, nw, mem[8]);
    end
    exp_mem[8] = 32'hABCD3344;
  endtask

  task automatic test_random_dm;
    int lat, nw, exp_lat, exp_nw, idx;
    logic [31:0] rd, a, wd, exp_rd;
    logic we, uns, mis, sub;
    logic [1:0] sz;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 255)); wd = $urandom; idx = int'(a[7:2]);
      mis = is_mis(sz, a);
      sub = sz == 2'd1 || sz == 2'd2;
      exp_lat = mis ? 1 : !we ? 2 : sub ? 3 : 1;
      exp_nw = (mis || !we) ? 0 : 1;
      exp_rd = mis ? 32'h0 : ref_load(exp_mem[idx], sz, a, uns);
      if (we && !mis) exp_mem[idx] = sub ? ref_store(exp_mem[idx], wd, sz, a) : wd;
      do_dm(we, sz, uns, a, wd, lat, rd, nw);
      n_cmp++;
      if (lat !== exp_lat || nw !== exp_nw) begin
        n_err++;
        $display("FAIL rand_timing op %0d we=%b sz=%0d a=%h: got lat=%0d writes=%0d want lat=%0d writes=%0d",
                 i, we, sz, a, lat, nw, exp_lat, exp_nw);
      end
      if (!we) begin
        n_cmp++;
        if (rd !== exp_rd) begin
          n_err++;
          $display("FAIL rand_load op %0d sz=%0d u=%b a=%h: got %h want %h", i, sz, uns, a, rd, exp_rd);
        end
      end
      n_cmp++;
      if (mem[idx] !== exp_mem[idx]) begin
        n_err++;
        $display("FAIL rand_mem op %0d a=%h: got %h want %h", i, a, mem[idx], exp_mem[idx]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int done;
    logic [31:0] exp_drd;
    logic [31:0] a;
    logic nxt_if, nxt_dm;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'($urandom_range(0, 255));
    dm_req = 1'b1; dm_we = 1'b0;
    nxt_dm = 1'b1;
    done = 0;
    for (int c = 0; c < 40 && done < 8; c++) begin
      if (nxt_dm) begin
        dm_size = 2'($urandom_range(0, 3)); dm_unsigned = 1'($urandom_range(0, 1));
        a = 32'($urandom_range(0, 255));
        dm_addr = MIS_EN ? (a & ~32'h3) : a;
        exp_drd = ref_load(exp_mem[dm_addr[7:2]], dm_size, dm_addr, dm_unsigned);
      end
      nxt_if = 1'b0; nxt_dm = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (if_ready && dm_ready) begin
        n_err++;
        $display("FAIL both_ready cycle %0d: got if_ready=1 dm_ready=1 want at most one", c);
      end
      if (if_ready || dm_ready) begin
        n_cmp++;
        if (if_ready !== (done % 2 == 1) || c != 2 * done + 1) begin
          n_err++;
          $display("FAIL grant_order #%0d: got port=%s cycle=%0d want port=%s cycle=%0d",
                   done, if_ready ? "IF" : "DM", c, (done % 2 == 1) ? "IF" : "DM", 2 * done + 1);
        end
        n_cmp++;
        if (if_ready && if_rdata !== exp_mem[if_addr[7:2]]) begin
          n_err++;
          $display("FAIL fetch_data a=%h: got %h want %h", if_addr, if_rdata, exp_mem[if_addr[7:2]]);
        end else if (dm_ready && dm_rdata !== exp_drd) begin
          n_err++;
          $display("FAIL alt_load a=%h: got %h want %h", dm_addr, dm_rdata, exp_drd);
        end
        nxt_if = if_ready;
        nxt_dm = dm_ready;
        done++;
      end
      tick();
      if (nxt_if) if_addr = 32'($urandom_range(0, 255));
    end
    n_cmp++;
    if (done !== 8) begin
      n_err++;
      $display("FAIL alt_completions: got %0d want 8", done);
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_rmw;
    set_word(32'h30, 32'h55667788);
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b01; dm_addr = 32'h30; dm_wdata = 32'h1234;
    @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_issue: got en=%b we=%b want en=1 we=0", mem_en, mem_we);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({dm_ready, if_ready, mem_en, mem_we, mem_wdata, dm_rdata} !== '0) begin
      n_err++;
      $display("FAIL rmw_reset_outputs: got rdy=%b en=%b we=%b wd=%h want all 0", dm_ready, mem_en, mem_we, mem_wdata);
    end
    tick();
    reset = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({dm_ready, mem_en, mem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL rmw_after_reset: got rdy=%b en=%b we=%b want 000 (idle)", dm_ready, mem_en, mem_we);
    end
    tick();
    n_cmp++;
    if (mem[12] !== 32'h55667788) begin
      n_err++;
      $display("FAIL rmw_no_write: got %h want 55667788", mem[12]);
    end
  endtask

`ifdef MEM_ARB_MISALIGN_EN
  task automatic test_misalign;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 32'h21;
    @(negedge clk);
    n_cmp++;
    if ({misalign, dm_ready, mem_en, dm_rdata} !== {3'b110, 32'h0}) begin
      n_err++;
      $display("FAIL misalign_word: got mis=%b rdy=%b en=%b rd=%h want 1 1 0 0", misalign, dm_ready, mem_en, dm_rdata);
    end
    tick();
    dm_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random_dm();
    test_back_to_back();
    test_reset_rmw();
`ifdef MEM_ARB_MISALIGN_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
